// File: rtl/dflow_pkg.sv
// dflow_pkg: shared widths and FSM states for the flow record/replay engine
package dflow_pkg;
  localparam int PKT_TUPLE_WIDTH = 104;
  localparam int PKT_LEN_WIDTH = 16;
  localparam int QDR_ADDR_WIDTH = 19;
  localparam int QDR_DATA_WIDTH = 36;
  localparam int QDR_BURST_LENGTH = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int REC_W = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;
  localparam int WORD_W = QDR_DATA_WIDTH * QDR_BURST_LENGTH;
  localparam int CNT_W = QDR_ADDR_WIDTH + 1;
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic [2:0] {IDLE, STORE, REPLAY, DRAIN, DONE} state_t;
endpackage

// File: rtl/dflow_generator_fifo.sv
// dflow_sync_fifo: first-word-fall-through sync FIFO; head reads as zero while empty
module dflow_sync_fifo #(
  parameter int W = 120,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign wr = push && count != (AW+1)'(DEPTH);
  assign rd = pop && !empty;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/dflow_generator.sv
// dflow_generator: records flow tuples into a QDR region and replays them in order
module dflow_generator
  import dflow_pkg::*;
(
  input  logic                       qdr_clk,
  input  logic                       resetn,
  input  logic                       sw_rst,
  input  logic                       start_store,
  input  logic                       start_replay,
  output logic                       compelete_replay,
  input  logic [QDR_ADDR_WIDTH-1:0]  mem_addr_low,
  input  logic [QDR_ADDR_WIDTH-1:0]  mem_addr_high,
  input  logic                       init_calib_complete,
  output logic                       user_app_wr_cmd,
  output logic [QDR_ADDR_WIDTH-1:0]  user_app_wr_addr,
  output logic [WORD_W-1:0]          user_app_wr_data,
  output logic                       user_app_rd_cmd,
  output logic [QDR_ADDR_WIDTH-1:0]  user_app_rd_addr,
  input  logic                       user_app_rd_valid,
  input  logic [WORD_W-1:0]          user_app_rd_data,
  input  logic [PKT_TUPLE_WIDTH-1:0] fivetuple_data_in,
  input  logic [PKT_LEN_WIDTH-1:0]   pkt_len_in,
  input  logic                       tuple_in_vld,
  output logic                       tuple_in_ready,
  output logic [PKT_TUPLE_WIDTH-1:0] fivetuple_data_out,
  output logic [PKT_LEN_WIDTH-1:0]   pkt_len_out,
  output logic                       tuple_out_vld,
  input  logic                       tuple_out_ready
);
  state_t state, state_nxt;
  logic rst, full, accept, issue, last_issue, push, pop, empty;
  logic [CNT_W-1:0] count, rd_issued, region;
  logic [QDR_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_CW-1:0] fifo_cnt, outstanding;
  logic [FIFO_CW:0] inflight;
  logic [REC_W-1:0] head;
  logic unused_bits;
  assign rst = resetn || sw_rst;
  assign region = (mem_addr_high < mem_addr_low) ? '0
                : {1'b0, mem_addr_high} - {1'b0, mem_addr_low} + CNT_W'(1);
  assign full = count >= region;
  assign accept = tuple_in_vld && tuple_in_ready;
  // reads in flight are reserved FIFO slots, so back-pressure can never overflow it
  assign inflight = (FIFO_CW+1)'(fifo_cnt) + (FIFO_CW+1)'(outstanding);
  assign issue = state == REPLAY && init_calib_complete && rd_issued < count
              && inflight < (FIFO_CW+1)'(FIFO_DEPTH);
  assign last_issue = issue && rd_issued == count - CNT_W'(1);
  assign push = user_app_rd_valid && (state == REPLAY || state == DRAIN);
  assign pop = tuple_out_vld && tuple_out_ready;
  assign tuple_out_vld = !empty;
  assign fivetuple_data_out = head[REC_W-1:PKT_LEN_WIDTH];
  assign pkt_len_out = head[PKT_LEN_WIDTH-1:0];
  assign unused_bits = &{1'b0, user_app_rd_data[WORD_W-1:REC_W]};
  always_ff @(posedge qdr_clk)
    state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (start_store && init_calib_complete) ? STORE
                         : (start_replay && count != '0 && init_calib_complete) ? REPLAY : IDLE;
      STORE:   state_nxt = start_store ? STORE : IDLE;
      REPLAY:  state_nxt = last_issue ? DRAIN : REPLAY;
      DRAIN:   state_nxt = (outstanding == '0 && empty) ? DONE : DRAIN;
      DONE:    state_nxt = start_replay ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    tuple_in_ready = state == STORE && init_calib_complete && !full;
    compelete_replay = state == DONE;
  end
  always_ff @(posedge qdr_clk) begin
    if (rst) begin
      user_app_wr_cmd <= 1'b0;
      user_app_wr_addr <= '0;
      user_app_wr_data <= '0;
      user_app_rd_cmd <= 1'b0;
      user_app_rd_addr <= '0;
      wr_ptr <= mem_addr_low;
      rd_ptr <= mem_addr_low;
      count <= '0;
      rd_issued <= '0;
      outstanding <= '0;
    end else begin
      user_app_wr_cmd <= accept;
      user_app_rd_cmd <= issue;
      outstanding <= outstanding + FIFO_CW'(issue) - FIFO_CW'(push);
      if (accept) begin
        user_app_wr_addr <= wr_ptr;
        user_app_wr_data <= {{(WORD_W-REC_W){1'b0}}, fivetuple_data_in, pkt_len_in};
        wr_ptr <= wr_ptr + QDR_ADDR_WIDTH'(1);
        count <= count + CNT_W'(1);
      end
      if (issue) begin
        user_app_rd_addr <= rd_ptr;
        rd_ptr <= rd_ptr + QDR_ADDR_WIDTH'(1);
        rd_issued <= rd_issued + CNT_W'(1);
      end
      if (state == IDLE && state_nxt == REPLAY) begin
        rd_ptr <= mem_addr_low;
        rd_issued <= '0;
      end
    end
  end
  dflow_sync_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (qdr_clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (user_app_rd_data[REC_W-1:0]),
    .dout  (head),
    .empty (empty),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_dflow_generator.sv
// tb_dflow_generator: random store/replay traffic against a QDR model and a record-list reference
module tb_dflow_generator;
  logic qdr_clk, resetn, sw_rst, start_store, start_replay, compelete_replay;
  logic [18:0] mem_addr_low, mem_addr_high, user_app_wr_addr, user_app_rd_addr;
  logic init_calib_complete, user_app_wr_cmd, user_app_rd_cmd, user_app_rd_valid;
  logic [143:0] user_app_wr_data, user_app_rd_data;
  logic [103:0] fivetuple_data_in, fivetuple_data_out;
  logic [15:0] pkt_len_in, pkt_len_out;
  logic tuple_in_vld, tuple_in_ready, tuple_out_vld, tuple_out_ready;

  dflow_generator dut (
    .qdr_clk(qdr_clk), .resetn(resetn), .sw_rst(sw_rst),
    .start_store(start_store), .start_replay(start_replay), .compelete_replay(compelete_replay),
    .mem_addr_low(mem_addr_low), .mem_addr_high(mem_addr_high),
    .init_calib_complete(init_calib_complete),
    .user_app_wr_cmd(user_app_wr_cmd), .user_app_wr_addr(user_app_wr_addr),
    .user_app_wr_data(user_app_wr_data), .user_app_rd_cmd(user_app_rd_cmd),
    .user_app_rd_addr(user_app_rd_addr), .user_app_rd_valid(user_app_rd_valid),
    .user_app_rd_data(user_app_rd_data), .fivetuple_data_in(fivetuple_data_in),
    .pkt_len_in(pkt_len_in), .tuple_in_vld(tuple_in_vld), .tuple_in_ready(tuple_in_ready),
    .fivetuple_data_out(fivetuple_data_out), .pkt_len_out(pkt_len_out),
    .tuple_out_vld(tuple_out_vld), .tuple_out_ready(tuple_out_ready)
  );

  typedef struct { logic [18:0] a; logic [143:0] d; } wr_t;
  wr_t exp_wr[$];
  logic [18:0] exp_rd[$];
  logic [119:0] exp_out[$];
  logic [119:0] m_recs[$];
  int m_low, m_high, m_count;
  int n_cmp = 0, n_bad = 0, rd_seen = 0, out_popped = 0;
  logic [143:0] qmem [int];
  logic [144:0] pipe0 = '0, pipe1 = '0;
  logic hold = 0;
  logic [119:0] held;
  wr_t e;

  initial qdr_clk = 0;
  always #5 qdr_clk = ~qdr_clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected transfer expected none", nm);
  endtask

  task automatic step();
    @(posedge qdr_clk);
    #1;
  endtask

  function automatic int region_size();
    return (m_high >= m_low) ? m_high - m_low + 1 : 0;
  endfunction

  // QDR model: two-cycle read latency, junk in the unused top 24 bits of read data
  always @(negedge qdr_clk) begin
    logic [143:0] junk;
    user_app_rd_valid = pipe1[144];
    user_app_rd_data = pipe1[143:0];
    pipe1 = pipe0;
    junk = {24'($urandom()), 120'b0};
    pipe0 = '0;
    if (user_app_rd_cmd)
      pipe0 = {1'b1, junk | (qmem.exists(int'(user_app_rd_addr)) ? qmem[int'(user_app_rd_addr)] : 144'b0)};
    if (user_app_wr_cmd) qmem[int'(user_app_wr_addr)] = user_app_wr_data;
  end

  // monitor / scoreboard
  always @(negedge qdr_clk) begin
    if (user_app_wr_cmd) begin
      if (exp_wr.size() == 0) unexp("wr_cmd");
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", 144'(user_app_wr_addr), 144'(e.a));
        check("wr_data", user_app_wr_data, e.d);
      end
    end
    if (user_app_rd_cmd) begin
      rd_seen++;
      if (exp_rd.size() == 0) unexp("rd_cmd");
      else check("rd_addr", 144'(user_app_rd_addr), 144'(exp_rd.pop_front()));
    end
    if (hold) begin
      check("hold_vld", 144'(tuple_out_vld), 144'(1));
      check("hold_data", 144'({fivetuple_data_out, pkt_len_out}), 144'(held));
    end
    if (tuple_out_vld && tuple_out_ready) begin
      out_popped++;
      if (exp_out.size() == 0) unexp("tuple_out");
      else check("tuple_out", 144'({fivetuple_data_out, pkt_len_out}), 144'(exp_out.pop_front()));
    end
    if (rd_seen != out_popped) check("inflight_le16", 144'(rd_seen - out_popped <= 16), 144'(1));
    hold = tuple_out_vld && !tuple_out_ready && !sw_rst && !resetn;
    held = {fivetuple_data_out, pkt_len_out};
  end

  task automatic do_reset(input int low, input int high, input bit sw);
    mem_addr_low = 19'(low);
    mem_addr_high = 19'(high);
    if (sw) sw_rst = 1; else resetn = 1;
    step();
    check("rst_wr_cmd", 144'(user_app_wr_cmd), 0);
    check("rst_wr_addr", 144'(user_app_wr_addr), 0);
    check("rst_wr_data", user_app_wr_data, 0);
    check("rst_rd_cmd", 144'(user_app_rd_cmd), 0);
    check("rst_rd_addr", 144'(user_app_rd_addr), 0);
    check("rst_in_ready", 144'(tuple_in_ready), 0);
    check("rst_out_vld", 144'(tuple_out_vld), 0);
    check("rst_out_data", 144'({fivetuple_data_out, pkt_len_out}), 0);
    check("rst_complete", 144'(compelete_replay), 0);
    sw_rst = 0;
    resetn = 0;
    exp_wr.delete(); exp_rd.delete(); exp_out.delete(); m_recs.delete();
    m_low = low; m_high = high; m_count = 0;
    rd_seen = 0; out_popped = 0;
  endtask

  task automatic store(input int n, input bit idx);
    logic [127:0] r;
    logic [103:0] t;
    logic [15:0] l;
    bit acc;
    start_store = 1;
    step();
    for (int i = 0; i < n; i++) begin
      while (!idx && $urandom_range(0, 3) == 0) step();
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      t = idx ? 104'(i) : r[103:0];
      l = idx ? 16'(i) : 16'($urandom());
      tuple_in_vld = 1; fivetuple_data_in = t; pkt_len_in = l;
      acc = m_count < region_size();
      @(negedge qdr_clk);
      check("in_ready", 144'(tuple_in_ready), 144'(acc));
      if (acc) begin
        exp_wr.push_back('{a: 19'(m_low + m_count), d: {24'b0, t, l}});
        m_recs.push_back({t, l});
        m_count++;
      end
      step();
      tuple_in_vld = 0;
    end
    start_store = 0;
    repeat (3) step();
  endtask

  task automatic replay();
    int k;
    for (int i = 0; i < m_count; i++) begin
      exp_rd.push_back(19'(m_low + i));
      exp_out.push_back(m_recs[i]);
    end
    start_replay = 1;
    k = 0;
    while (!compelete_replay && k < 3000) begin
      tuple_out_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    check("replay_done", 144'(compelete_replay), 1);
    check("rd_left", 144'(exp_rd.size()), 0);
    check("out_left", 144'(exp_out.size()), 0);
    start_replay = 0;
    tuple_out_ready = 0;
    step(); step();
    check("done_clear", 144'(compelete_replay), 0);
  endtask

  initial begin
    resetn = 1; sw_rst = 0; start_store = 0; start_replay = 0;
    init_calib_complete = 0; tuple_in_vld = 0; tuple_out_ready = 0;
    fivetuple_data_in = '0; pkt_len_in = '0;
    mem_addr_low = '0; mem_addr_high = '0;
    step();
    do_reset(0, 1000, 0);
    start_store = 1; tuple_in_vld = 1;
    repeat (5) begin
      step();
      check("calib_ready", 144'(tuple_in_ready), 0);
    end
    tuple_in_vld = 0;
    init_calib_complete = 1;
    store(16, 1);
    replay();
    do_reset(0, 3, 1);
    store(6, 0);
    replay();
    do_reset(10, 5, 1);
    store(2, 0);
    do_reset(100, 200, 1);
    store(10, 0);
    for (int i = 0; i < 10; i++) begin
      exp_rd.push_back(19'(m_low + i));
      exp_out.push_back(m_recs[i]);
    end
    start_replay = 1;
    repeat (6) begin
      tuple_out_ready = 1'($urandom_range(0, 1));
      step();
    end
    do_reset(100, 200, 1);
    repeat (10) step();
    check("no_replay_after_rst", 144'(compelete_replay), 0);
    start_replay = 0;
    step();
    store(12, 0);
    replay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
